pooling_layer_window_stream_buffer: RTL and testbench
=====================================================

// Module: pooling_layer_window_stream_buffer
// PURPOSE
//  Parametrised multi-channel successor of the pooling input buffer. Captures one KERNEL_SIZE-word
//  row per channel when the conv stage strobes kernel_calc_fin, then streams the words out
//  one per beat, all channels in lockstep, under a valid/ready handshake. Adds a block tag,
//  a last-beat marker and a sticky overflow flag. Sits between the conv output and the pooling comparator.
// PARAMETERS
//  DATA_WIDTH   32  bits per word (matches `DATA_WIDTH)
//  KERNEL_SIZE  2   words per row per channel (>=2)
//  CHANNELS     1   parallel channels shifted in lockstep (>=1)
//  BIDX_W       3   width of block_idx tag
// PORTS
//  clk            in   1                            clock, all logic on posedge
//  rst_n          in   1                            async active-low reset
//  kernel_calc_fin in  1                            load strobe (accepted only when load_ready=1)
//  block_idx      in   BIDX_W                       tag captured with the load
//  data_in        in   CHANNELS*KERNEL_SIZE*DATA_WIDTH  ch c at [(c+1)*K*DW-1 -: K*DW]; word0 = MS slice
//  out_ready      in   1                            downstream accepts beat
//  ovf_clr        in   1                            clears overflow (sync)
//  load_ready     out  1                            buffer can take a load this cycle
//  out_valid      out  1                            data_out holds a valid beat
//  data_out       out  CHANNELS*DATA_WIDTH          current word of every channel, ch c at [(c+1)*DW-1 -: DW]
//  out_last       out  1                            current beat is word KERNEL_SIZE-1
//  out_block_idx  out  BIDX_W                       tag of row being streamed
//  overflow       out  1                            sticky: a load was dropped
// BEHAVIOUR
//  - Reset: state IDLE, all buffer words 0, beat cnt 0; out_valid=0, out_last=0, data_out=0,
//    out_block_idx=0, overflow=0, load_ready=1. Reset mid-stream discards the row immediately.
//  - FSM IDLE->DRAIN on accepted load (kernel_calc_fin & load_ready); DRAIN->IDLE on accept of last beat.
//  - Load: per channel the K words are registered into a shift reg; cnt<=0; tag latched.
//    Latency: load at edge N -> out_valid=1 with word0 visible after edge N (1 cycle).
//  - DRAIN: out_valid=1; data_out = shift-reg head of each channel; out_last=(cnt==K-1).
//    Beat accepted when out_valid & out_ready: shift towards head, zero-fill tail, cnt++.
//    out_ready=0 holds data_out/cnt stable (no loss, no duplication).
//  - After last accept (no pending row): out_valid=0, data_out=0 (zero-filled), cnt=0.
//  - Dropped load: kernel_calc_fin & !load_ready -> stream unaffected, overflow<=1.
//    ovf_clr clears overflow; ovf_clr and a drop in same cycle -> overflow stays 1.
//  - cnt width clog2(KERNEL_SIZE); never wraps past K-1.
//  - No arithmetic on data; words pass bit-exact.
// CONFIGURATION
//  POOL_IBUF_PINGPONG_EN defined: adds a shadow bank (data + tag + full bit).
//    load_ready = !shadow_full. Load in IDLE -> main bank. Load in DRAIN -> shadow.
//    On last-beat accept with shadow_full: shadow promoted to main, cnt<=0, stay DRAIN,
//    next row's word0 valid on next cycle (zero bubble). Load in the same cycle as last
//    accept with shadow empty -> goes straight to main, no bubble.
//  Not defined: single bank, load_ready = (state==IDLE); any load during DRAIN
//    (incl. last-beat cycle) is dropped and sets overflow.
// TESTING
//  1 K=2,CH=1: load {A,B} tag 5, out_ready=1 -> beats A then B(last=1), tag 5, then valid=0, data_out=0.
//  2 K=3,CH=2: load ch1 {1,2,3} ch0 {4,5,6}, out_ready toggling 1,0,1,0,1 -> {1,4},{2,5},{3,6}; each held during stalls.
//  3 No PINGPONG: load during beat 0 -> dropped, overflow=1 until ovf_clr; stream unaffected.
//  4 PINGPONG: row X then row Y loaded during X -> X0,X1,Y0,Y1 back-to-back, no bubble; 3rd load while shadow full -> overflow.
//  5 rst_n low mid-DRAIN (after beat 0) -> all outputs reset values at once; after release new load streams from word0.
//  6 Load & ovf_clr same cycle in IDLE -> load accepted, overflow=0.

Source files
------------

// File: rtl/pooling_layer_window_stream_buffer_if.sv
// Handshake/bus bundle for pooling_layer_window_stream_buffer.
// The master side (conv stage plus pooling comparator) drives loads and out_ready.
// The slave side is the buffer, which drives the stream and its status.
interface pooling_layer_window_stream_buffer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 2,
  parameter int CHANNELS    = 1,
  parameter int BIDX_W      = 3
);
  logic                                     kernel_calc_fin;
  logic [BIDX_W-1:0]                        block_idx;
  logic [CHANNELS*KERNEL_SIZE*DATA_WIDTH-1:0] data_in;
  logic                                     out_ready;
  logic                                     ovf_clr;
  logic                                     load_ready;
  logic                                     out_valid;
  logic [CHANNELS*DATA_WIDTH-1:0]           data_out;
  logic                                     out_last;
  logic [BIDX_W-1:0]                        out_block_idx;
  logic                                     overflow;

  modport master (
    output kernel_calc_fin, block_idx, data_in, out_ready, ovf_clr,
    input  load_ready, out_valid, data_out, out_last, out_block_idx, overflow
  );

  modport slave (
    input  kernel_calc_fin, block_idx, data_in, out_ready, ovf_clr,
    output load_ready, out_valid, data_out, out_last, out_block_idx, overflow
  );
endinterface

// File: rtl/pooling_layer_window_stream_buffer.sv
// pooling_layer_window_stream_buffer
// Captures one KERNEL_SIZE-word row per channel on kernel_calc_fin.
// It then streams the row out one word per beat, with all channels in lockstep,
// under a valid/ready handshake. Each row carries a block tag and a last-beat marker.
// A sticky overflow flag records any load that had to be dropped.
// Optional feature macro: POOL_IBUF_PINGPONG_EN.
//   When it is defined, a shadow bank holds the next row while the current one drains.
//   Rows then stream back-to-back with no idle cycle between them.
//   When it is undefined, there is a single bank and loads are taken only in IDLE.
module pooling_layer_window_stream_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 2,
  parameter int CHANNELS    = 1,
  parameter int BIDX_W      = 3
) (
  input  logic clk,
  input  logic rst_n,
  pooling_layer_window_stream_buffer_if.slave bus
);

  localparam int ROW_W  = KERNEL_SIZE * DATA_WIDTH;
  localparam int BANK_W = CHANNELS * ROW_W;
  localparam int CNT_W  = $clog2(KERNEL_SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KERNEL_SIZE - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Move every channel one word towards its head (MS slice) and zero-fill the tail.
  function automatic logic [BANK_W-1:0] shift_bank(input logic [BANK_W-1:0] bank);
    logic [BANK_W-1:0] res;
    res = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      res[c*ROW_W +: ROW_W] = bank[c*ROW_W +: ROW_W] << DATA_WIDTH;
    end
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [BANK_W-1:0] bank_q,  bank_d;
  logic [BIDX_W-1:0] tag_q,   tag_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              ovf_q,   ovf_d;
`ifdef POOL_IBUF_PINGPONG_EN
  logic [BANK_W-1:0] sh_bank_q, sh_bank_d;
  logic [BIDX_W-1:0] sh_tag_q,  sh_tag_d;
  logic              sh_full_q, sh_full_d;
`endif

  logic load_ready_s;
  logic load_acc_s;
  logic drop_s;
  logic beat_acc_s;
  logic last_s;

  // Handshake qualifiers: load acceptance, dropped loads and beat acceptance.
  always_comb begin
`ifdef POOL_IBUF_PINGPONG_EN
    load_ready_s = !sh_full_q;
`else
    load_ready_s = (state_q == ST_IDLE);
`endif
    load_acc_s = bus.kernel_calc_fin && load_ready_s;
    drop_s     = bus.kernel_calc_fin && !load_ready_s;
    beat_acc_s = (state_q == ST_DRAIN) && bus.out_ready;
    last_s     = (cnt_q == LAST_CNT);
  end

  // Next-state logic for the FSM, both banks, the beat counter and the sticky overflow flag.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef POOL_IBUF_PINGPONG_EN
    sh_bank_d = sh_bank_q;
    sh_tag_d  = sh_tag_q;
    sh_full_d = sh_full_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_acc_s) begin
          bank_d  = bus.data_in;
          tag_d   = bus.block_idx;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (beat_acc_s && last_s) begin
`ifdef POOL_IBUF_PINGPONG_EN
          if (sh_full_q) begin
            // The waiting row takes over with no idle cycle in between.
            bank_d    = sh_bank_q;
            tag_d     = sh_tag_q;
            sh_full_d = 1'b0;
            cnt_d     = '0;
            state_d   = ST_DRAIN;
          end else if (load_acc_s) begin
            // A load that coincides with the final beat goes straight into the main bank.
            bank_d  = bus.data_in;
            tag_d   = bus.block_idx;
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            bank_d  = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
`else
          bank_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
`endif
        end else begin
          if (beat_acc_s) begin
            bank_d = shift_bank(bank_q);
            cnt_d  = cnt_q + CNT_W'(1);
          end else begin
            bank_d = bank_q;
          end
`ifdef POOL_IBUF_PINGPONG_EN
          if (load_acc_s) begin
            sh_bank_d = bus.data_in;
            sh_tag_d  = bus.block_idx;
            sh_full_d = 1'b1;
          end else begin
            sh_full_d = sh_full_q;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        bank_d  = '0;
        cnt_d   = '0;
      end
    endcase
    // A drop wins over a clear that arrives in the same cycle.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers. Reset discards any row immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bank_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef POOL_IBUF_PINGPONG_EN
      sh_bank_q <= '0;
      sh_tag_q  <= '0;
      sh_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
`ifdef POOL_IBUF_PINGPONG_EN
      sh_bank_q <= sh_bank_d;
      sh_tag_q  <= sh_tag_d;
      sh_full_q <= sh_full_d;
`endif
    end
  end

  // The head word of each channel drives data_out directly from the bank register.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_head
    assign bus.data_out[c*DATA_WIDTH +: DATA_WIDTH] =
      bank_q[c*ROW_W + ROW_W - DATA_WIDTH +: DATA_WIDTH];
  end

  assign bus.load_ready    = load_ready_s;
  assign bus.out_valid     = (state_q == ST_DRAIN);
  assign bus.out_last      = (state_q == ST_DRAIN) && last_s;
  assign bus.out_block_idx = tag_q;
  assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_pooling_layer_window_stream_buffer.sv
// Directed bench for pooling_layer_window_stream_buffer.
// u_a uses K=2 and CH=1 with 32-bit words.
// u_b uses K=3 and CH=2 with 8-bit words.
// Rows are single-bank or ping-pong depending on POOL_IBUF_PINGPONG_EN.
module tb_pooling_layer_window_stream_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  pooling_layer_window_stream_buffer_if #(.DATA_WIDTH(32), .KERNEL_SIZE(2), .CHANNELS(1), .BIDX_W(3)) ia ();
  pooling_layer_window_stream_buffer_if #(.DATA_WIDTH(8),  .KERNEL_SIZE(3), .CHANNELS(2), .BIDX_W(3)) ib ();

  pooling_layer_window_stream_buffer #(.DATA_WIDTH(32), .KERNEL_SIZE(2), .CHANNELS(1), .BIDX_W(3)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  pooling_layer_window_stream_buffer #(.DATA_WIDTH(8), .KERNEL_SIZE(3), .CHANNELS(2), .BIDX_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  // Free-running clock with a period of 10 time units.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks all outputs of u_a in one call.
  task automatic chk_a(input string tag, input logic v, input logic [31:0] d, input logic l,
                       input logic [2:0] t, input logic o);
    chk({tag, ".valid"}, 64'(ia.out_valid), 64'(v));
    chk({tag, ".data"},  64'(ia.data_out), 64'(d));
    chk({tag, ".last"},  64'(ia.out_last), 64'(l));
    chk({tag, ".tag"},   64'(ia.out_block_idx), 64'(t));
    chk({tag, ".ovf"},   64'(ia.overflow), 64'(o));
  endtask

  initial begin
    ia.kernel_calc_fin = 1'b0; ia.block_idx = 3'd0; ia.data_in = 64'd0; ia.out_ready = 1'b0; ia.ovf_clr = 1'b0;
    ib.kernel_calc_fin = 1'b0; ib.block_idx = 3'd0; ib.data_in = 48'd0; ib.out_ready = 1'b0; ib.ovf_clr = 1'b0;

    // Reset values.
    tick();
    chk_a("rst", 1'b0, 32'd0, 1'b0, 3'd0, 1'b0);
    chk("rst.load_ready", 64'(ia.load_ready), 64'd1);
    chk("rst.b_data", 64'(ib.data_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: K=2 and CH=1. Row {A,B} with tag 5 streams with out_ready held high.
    ia.kernel_calc_fin = 1'b1; ia.block_idx = 3'd5; ia.data_in = {32'hA0A0_0001, 32'hB0B0_0002}; ia.out_ready = 1'b1;
    tick();
    ia.kernel_calc_fin = 1'b0;
    chk_a("t1.beat0", 1'b1, 32'hA0A0_0001, 1'b0, 3'd5, 1'b0);
`ifdef POOL_IBUF_PINGPONG_EN
    chk("t1.load_ready", 64'(ia.load_ready), 64'd1);
`else
    chk("t1.load_ready", 64'(ia.load_ready), 64'd0);
`endif
    tick();
    chk_a("t1.beat1", 1'b1, 32'hB0B0_0002, 1'b1, 3'd5, 1'b0);
    tick();
    chk_a("t1.done", 1'b0, 32'd0, 1'b0, 3'd5, 1'b0);
    chk("t1.load_ready_idle", 64'(ia.load_ready), 64'd1);

    // Test 2: K=3 and CH=2 with out_ready stalls. ch1 holds {1,2,3} and ch0 holds {4,5,6}.
    ib.kernel_calc_fin = 1'b1; ib.block_idx = 3'd2; ib.data_in = 48'h010203_040506; ib.out_ready = 1'b0;
    tick();
    ib.kernel_calc_fin = 1'b0;
    chk("t2.b0.valid", 64'(ib.out_valid), 64'd1);
    chk("t2.b0.data", 64'(ib.data_out), 64'h0104);
    chk("t2.b0.tag", 64'(ib.out_block_idx), 64'd2);
    ib.out_ready = 1'b1; tick();
    chk("t2.b1.data", 64'(ib.data_out), 64'h0205);
    chk("t2.b1.last", 64'(ib.out_last), 64'd0);
    ib.out_ready = 1'b0; tick();
    chk("t2.b1hold.data", 64'(ib.data_out), 64'h0205);
    chk("t2.b1hold.valid", 64'(ib.out_valid), 64'd1);
    ib.out_ready = 1'b1; tick();
    chk("t2.b2.data", 64'(ib.data_out), 64'h0306);
    chk("t2.b2.last", 64'(ib.out_last), 64'd1);
    ib.out_ready = 1'b0; tick();
    chk("t2.b2hold.data", 64'(ib.data_out), 64'h0306);
    chk("t2.b2hold.last", 64'(ib.out_last), 64'd1);
    ib.out_ready = 1'b1; tick();
    chk("t2.done.valid", 64'(ib.out_valid), 64'd0);
    chk("t2.done.data", 64'(ib.data_out), 64'd0);
    ib.out_ready = 1'b0;

`ifdef POOL_IBUF_PINGPONG_EN
    // Test 4: row Y is loaded into the shadow bank during X. Rows then stream with no gap.
    // A third load while the shadow bank is full sets overflow.
    ia.kernel_calc_fin = 1'b1; ia.block_idx = 3'd1; ia.data_in = {32'h0000_00A1, 32'h0000_00A2}; ia.out_ready = 1'b1;
    tick();
    chk_a("t4.x0", 1'b1, 32'h0000_00A1, 1'b0, 3'd1, 1'b0);
    ia.block_idx = 3'd3; ia.data_in = {32'h0000_00B1, 32'h0000_00B2};
    tick();
    chk_a("t4.x1", 1'b1, 32'h0000_00A2, 1'b1, 3'd1, 1'b0);
    chk("t4.shadow_full", 64'(ia.load_ready), 64'd0);
    ia.block_idx = 3'd7; ia.data_in = {32'h0000_00C1, 32'h0000_00C2};
    tick();
    ia.kernel_calc_fin = 1'b0;
    chk_a("t4.y0", 1'b1, 32'h0000_00B1, 1'b0, 3'd3, 1'b1);
    chk("t4.y0.load_ready", 64'(ia.load_ready), 64'd1);
    tick();
    chk_a("t4.y1", 1'b1, 32'h0000_00B2, 1'b1, 3'd3, 1'b1);
    tick();
    chk_a("t4.done", 1'b0, 32'd0, 1'b0, 3'd3, 1'b1);
    ia.ovf_clr = 1'b1; tick(); ia.ovf_clr = 1'b0;
    chk("t4.ovf_clr", 64'(ia.overflow), 64'd0);
`else
    // Test 3: a load during beat 0 is dropped and sets overflow. The stream is unaffected.
    ia.kernel_calc_fin = 1'b1; ia.block_idx = 3'd2; ia.data_in = {32'hC0C0_0003, 32'hD0D0_0004}; ia.out_ready = 1'b1;
    tick();
    chk_a("t3.beat0", 1'b1, 32'hC0C0_0003, 1'b0, 3'd2, 1'b0);
    ia.block_idx = 3'd7; ia.data_in = {32'hE0E0_0005, 32'hF0F0_0006};
    tick();
    ia.kernel_calc_fin = 1'b0;
    chk_a("t3.beat1", 1'b1, 32'hD0D0_0004, 1'b1, 3'd2, 1'b1);
    tick();
    chk_a("t3.done", 1'b0, 32'd0, 1'b0, 3'd2, 1'b1);
    tick();
    chk("t3.ovf_sticky", 64'(ia.overflow), 64'd1);
    ia.ovf_clr = 1'b1; tick(); ia.ovf_clr = 1'b0;
    chk("t3.ovf_clr", 64'(ia.overflow), 64'd0);
`endif

    // Test 5: reset is applied mid-stream after beat 0. A fresh row then streams from word0.
    ia.kernel_calc_fin = 1'b1; ia.block_idx = 3'd4; ia.data_in = {32'h1234_5678, 32'h9ABC_DEF0}; ia.out_ready = 1'b1;
    tick();
    ia.kernel_calc_fin = 1'b0;
    chk_a("t5.beat0", 1'b1, 32'h1234_5678, 1'b0, 3'd4, 1'b0);
    tick();
    chk_a("t5.beat1", 1'b1, 32'h9ABC_DEF0, 1'b1, 3'd4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_a("t5.rst", 1'b0, 32'd0, 1'b0, 3'd0, 1'b0);
    chk("t5.rst.load_ready", 64'(ia.load_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ia.kernel_calc_fin = 1'b1; ia.block_idx = 3'd6; ia.data_in = {32'h0BAD_F00D, 32'hCAFE_BABE};
    tick();
    ia.kernel_calc_fin = 1'b0;
    chk_a("t5.new0", 1'b1, 32'h0BAD_F00D, 1'b0, 3'd6, 1'b0);
    tick();
    chk_a("t5.new1", 1'b1, 32'hCAFE_BABE, 1'b1, 3'd6, 1'b0);
    tick();
    chk_a("t5.done", 1'b0, 32'd0, 1'b0, 3'd6, 1'b0);

    // Test 6: a load and ovf_clr in the same IDLE cycle. The load is accepted and overflow stays 0.
    ia.kernel_calc_fin = 1'b1; ia.block_idx = 3'd0; ia.data_in = {32'h1111_1111, 32'h2222_2222};
    ia.ovf_clr = 1'b1; ia.out_ready = 1'b0;
    tick();
    chk_a("t6.load", 1'b1, 32'h1111_1111, 1'b0, 3'd0, 1'b0);
`ifndef POOL_IBUF_PINGPONG_EN
    // A drop and ovf_clr in the same cycle leave overflow set. The stalled beat is held.
    tick();
    chk_a("t6.drop_clr", 1'b1, 32'h1111_1111, 1'b0, 3'd0, 1'b1);
`endif
    ia.kernel_calc_fin = 1'b0; ia.ovf_clr = 1'b0; ia.out_ready = 1'b1;
    tick();
    chk("t6.beat1.data", 64'(ia.data_out), 64'h2222_2222);
    chk("t6.beat1.last", 64'(ia.out_last), 64'd1);
    tick();
    chk("t6.done.valid", 64'(ia.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
